instr_fetch_mem: RTL and testbench

//  Parametrised synchronous instruction memory for the MIPS fetch stage; successor to the

---
 rtl/mips_pkg.sv | 22 ++
 rtl/imem_ram.sv | 40 ++++
 rtl/instr_fetch_mem.sv | 91 +++++++++
 tb/tb_instr_fetch_mem.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS constants and the address fault decode used by the instruction and data memories.
// Pure declarations: no timing and no flow control.
package mips_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    typedef struct packed {
        logic misaligned;
        logic out_of_range;
    } fault_t;

    // The address is a byte address and word_bits is the word-index width.
    // Any set bit above the indexed words is a fault; the address never aliases.
    function automatic fault_t fault_cause(input logic [63:0] addr, input int unsigned word_bits);
        fault_t f;
        f.misaligned   = |addr[1:0];
        f.out_of_range = |(addr >> (word_bits + 2));
        return f;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-port-write, registered-read instruction RAM with write-first bypass; read latency 1 cycle.
// No backpressure: the read register holds its value whenever re is low.
module imem_ram #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_d, rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A same-cycle write to the word being read wins, so the reader sees the new data.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instr_fetch_mem.sv
// Fetch-stage instruction memory: byte PC in, tagged word out exactly 1 cycle later.
// Backpressure: stall freezes every output, and a request made during stall is dropped, not queued.
module instr_fetch_mem
    import mips_pkg::*;
#(
    parameter int                DATA_W    = mips_pkg::DATA_W_DEF,
    parameter int                ADDR_W    = 10,
    parameter int                PC_W      = 32,
    parameter logic [PC_W-1:0]   RESET_PC  = '0,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(mips_pkg::NOP_INSTR),
    parameter                    INIT_FILE = ""
) (
    input  logic              CLK_SYS,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic              stall,
    input  logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic [PC_W-1:0]   fetch_pc,
    output logic              fault,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data
);

    fault_t            cause;
    logic              bad_addr;
    logic              accept;
    logic              ram_re;
    logic              ram_we;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] ram_rdata;

    logic              valid_d,   valid_q;
    logic              fault_d,   fault_q;
    logic [PC_W-1:0]   pc_d,      pc_q;
    logic              nop_sel_d, nop_sel_q;

    always_comb begin
        cause    = fault_cause(64'(pc), ADDR_W);
        bad_addr = cause.misaligned | cause.out_of_range;
        idx      = pc[ADDR_W+1:2];
        accept   = fetch_req & ~stall;
        ram_re   = accept & ~bad_addr & ~rst;
        ram_we   = load_en & ~rst;
    end

    imem_ram #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (CLK_SYS),
        .we    (ram_we),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (ram_re),
        .raddr (idx),
        .rdata (ram_rdata)
    );

    // nop_sel remembers whether the held word is NOP (after reset or a fault), so the
    // instruction stays stable through idle cycles that clear the fault flag.
    always_comb begin
        valid_d   = stall ? valid_q : accept;
        fault_d   = stall ? fault_q : (accept & bad_addr);
        pc_d      = accept ? pc : pc_q;
        nop_sel_d = accept ? bad_addr : nop_sel_q;
    end

    always_ff @(posedge CLK_SYS) begin
        if (rst) begin
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            pc_q      <= RESET_PC;
            nop_sel_q <= 1'b1;
        end else begin
            valid_q   <= valid_d;
            fault_q   <= fault_d;
            pc_q      <= pc_d;
            nop_sel_q <= nop_sel_d;
        end
    end

    assign instruction = nop_sel_q ? NOP_INSTR : ram_rdata;
    assign instr_valid = valid_q;
    assign fetch_pc    = pc_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem: reset, load/fetch streaming, stall, faults, bypass, reset retention.
module tb_instr_fetch_mem;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int PC_W   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              fetch_req;
    logic              stall;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] instruction;
    logic              instr_valid;
    logic [PC_W-1:0]   fetch_pc;
    logic              fault;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch_mem #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .PC_W     (PC_W),
        .RESET_PC (32'h0),
        .NOP_INSTR(32'h0),
        .INIT_FILE("")
    ) dut (
        .CLK_SYS     (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .stall       (stall),
        .pc          (pc),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .fetch_pc    (fetch_pc),
        .fault       (fault),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge, once they have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] ins, input logic vld,
                              input logic [31:0] fpc, input logic flt);
        chk({tag, ".instruction"}, 64'(instruction), 64'(ins));
        chk({tag, ".instr_valid"}, 64'(instr_valid), 64'(vld));
        chk({tag, ".fetch_pc"},    64'(fetch_pc),    64'(fpc));
        chk({tag, ".fault"},       64'(fault),       64'(flt));
    endtask

    initial begin
        rst = 1'b1; fetch_req = 1'b0; stall = 1'b0; pc = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;

        // Reset with a request pending, which reset must override.
        fetch_req = 1'b1; pc = 32'h40;
        tick();
        tick();
        expect_out("reset", 32'h0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0; fetch_req = 1'b0;

        for (int i = 0; i < 32; i++) begin
            load_en = 1'b1; load_addr = ADDR_W'(i); load_data = 32'h2000_0000 + 32'(i);
            tick();
        end
        load_en = 1'b0;

        for (int i = 0; i < 32; i++) begin
            fetch_req = 1'b1; pc = 32'(4 * i);
            tick();
            expect_out($sformatf("stream%0d", i), 32'h2000_0000 + 32'(i), 1'b1, 32'(4 * i), 1'b0);
        end

        pc = 32'd8;
        tick();
        expect_out("stall_pre", 32'h2000_0002, 1'b1, 32'd8, 1'b0);
        stall = 1'b1; pc = 32'd12;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("stall%0d", i), 32'h2000_0002, 1'b1, 32'd8, 1'b0);
        end
        stall = 1'b0;
        tick();
        expect_out("stall_post", 32'h2000_0003, 1'b1, 32'd12, 1'b0);

        pc = 32'd6;
        tick();
        expect_out("misalign", 32'h0, 1'b1, 32'd6, 1'b1);
        pc = 32'h1000;
        tick();
        expect_out("range", 32'h0, 1'b1, 32'h1000, 1'b1);
        fetch_req = 1'b0;
        tick();
        expect_out("idle", 32'h0, 1'b0, 32'h1000, 1'b0);

        fetch_req = 1'b1; pc = 32'd20;
        load_en = 1'b1; load_addr = 10'd5; load_data = 32'hDEAD_BEEF;
        tick();
        expect_out("bypass", 32'hDEAD_BEEF, 1'b1, 32'd20, 1'b0);
        pc = 32'd28; load_addr = 10'd6; load_data = 32'h1234_5678;
        tick();
        expect_out("diffword", 32'h2000_0007, 1'b1, 32'd28, 1'b0);
        load_en = 1'b0; pc = 32'd24;
        tick();
        expect_out("diffword_rd", 32'h1234_5678, 1'b1, 32'd24, 1'b0);

        pc = 32'd4;
        tick();
        stall = 1'b1;
        tick();
        expect_out("rst_stall_pre", 32'h2000_0001, 1'b1, 32'd4, 1'b0);
        // A load attempted during reset must be ignored.
        rst = 1'b1; load_en = 1'b1; load_addr = 10'd0; load_data = 32'hFFFF_FFFF;
        tick();
        expect_out("rst_stall", 32'h0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0; stall = 1'b0; load_en = 1'b0; pc = 32'd0;
        tick();
        expect_out("retain", 32'h2000_0000, 1'b1, 32'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
